// File: rtl/mem_read_arbiter.sv
// Two-requester (fetch, load/store) read arbiter onto one single-outstanding read channel.
// Latency: 4 cycles grant-sample to *_valid (IDLE, AR, R, DONE) with immediate arready/rvalid.
// Backpressure: AR holds arvalid/araddr until arready; R holds rready until rvalid; no timeout.
module mem_read_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 64
) (
  input  logic              ACLK,
  input  logic              ARESET,
  // fetch requester
  input  logic              if_en,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [63:0]       if_rdata,
  // load/store requester
  input  logic              ls_en,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_valid,
  output logic [63:0]       ls_rdata,
  // downstream read channel
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [63:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  // status
  output logic              err,
  output logic              busy
);

  // Counter is wide enough to hold STARVE_MAX; at least one bit so STARVE_MAX=0 still elaborates.
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  state_t            state;
  state_t            state_nxt;
  owner_t            owner;
  logic [ADDR_W-1:0] araddr_q;
  logic [CNT_W-1:0]  starve_cnt;
  logic [63:0]       rd_dat_q;
  logic [1:0]        rresp_q;
  logic              dropped_q;

  logic              grant;
  logic              grant_ls;
  logic              capture;
  logic              deliver;
  logic              owner_en;
  logic              keep;
  logic              resp_ok;

  // The owner's enable as seen this cycle; used to detect a requester walking away.
  assign owner_en = (owner == OWN_LS) ? ls_en : if_en;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, arbitration and channel handshake outputs.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_ls  = 1'b0;
    capture   = 1'b0;
    deliver   = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (if_en || ls_en) begin
          grant     = 1'b1;
          // ls normally wins contention; fetch wins once it has been passed over STARVE_MAX times
          grant_ls  = ls_en && !(if_en && (starve_cnt == CNT_MAX));
          state_nxt = AR;
        end
      end
      AR: begin
        arvalid = 1'b1;
        busy    = 1'b1;
        if (arready) begin
          state_nxt = R;
        end
      end
      R: begin
        rready = 1'b1;
        busy   = 1'b1;
        if (rvalid) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // No grant here: the owner's enable is typically still high this cycle.
        busy      = 1'b1;
        deliver   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grant bookkeeping, abandonment tracking and read-data capture.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      araddr_q  <= '0;
      owner     <= OWN_IF;
      dropped_q <= 1'b0;
      rd_dat_q  <= '0;
      rresp_q   <= 2'b00;
    end else begin
      if (grant) begin
        araddr_q  <= grant_ls ? ls_addr : if_addr;
        owner     <= grant_ls ? OWN_LS : OWN_IF;
        dropped_q <= 1'b0;
      end else if ((state != IDLE) && !owner_en) begin
        // Sticky: once the owner lets go, the completion is not delivered even if it re-asserts.
        dropped_q <= 1'b1;
      end
      if (capture) begin
        rd_dat_q <= rdata;
        rresp_q  <= rresp;
      end
    end
  end

  // Starvation counter: counts ls grants taken while fetch was waiting, saturating.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!if_en) begin
        starve_cnt <= '0;
      end else if (grant && !grant_ls) begin
        starve_cnt <= '0;
      end else if (grant_ls && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Completion delivery: only to a still-interested owner; error responses deliver zero data.
  assign keep     = deliver && owner_en && !dropped_q;
  assign resp_ok  = (rresp_q == 2'b00);
  assign if_valid = keep && (owner == OWN_IF);
  assign ls_valid = keep && (owner == OWN_LS);
  assign err      = keep && !resp_ok;
  assign if_rdata = (if_valid && resp_ok) ? rd_dat_q : 64'd0;
  assign ls_rdata = (ls_valid && resp_ok) ? rd_dat_q : 64'd0;
  assign araddr   = (state == IDLE) ? '0 : araddr_q;

endmodule
